quad_encoder_counter: RTL and testbench

Multi-channel incremental quadrature decoder with per-channel signed position counters and per-channel illegal-transition counters.
Runtime-selectable x1/x2/x4 resolution and per-channel synchronous clear.
Phase inputs arrive already synchronised to CLK by an upstream sync chain.
Outputs feed display or control logic directly.

---
 rtl/qenc_pkg.sv | 50 +++++
 rtl/qenc_channel.sv | 103 ++++++++++
 rtl/quad_encoder_counter.sv | 50 +++++
 tb/tb_quad_encoder_counter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qenc_pkg.sv
// Shared definitions for the quadrature encoder counter.
//   - resolution mode encodings (i_mode)
//   - direction constants (o_dir)
//   - qenc_decode(): classifies a {A,B} state change as valid/illegal
//     and gives its direction
// Optional feature macro used elsewhere: QENC_SATURATE_EN.
package qenc_pkg;

  localparam logic [1:0] QENC_MODE_X1 = 2'b00;
  localparam logic [1:0] QENC_MODE_X2 = 2'b01;
  localparam logic [1:0] QENC_MODE_X4 = 2'b10;

  typedef enum logic {
    QENC_DIR_CCW = 1'b0,
    QENC_DIR_CW  = 1'b1
  } qenc_dir_e;

  typedef struct packed {
    logic      valid;
    logic      illegal;
    qenc_dir_e dir;
  } qenc_trans_t;

  // CW order is 00 -> 01 -> 11 -> 10 -> 00. A single-bit change is a valid
  // step in one direction; a two-bit change cannot be resolved and is illegal.
  function automatic qenc_trans_t qenc_decode(input logic [1:0] prev,
                                              input logic [1:0] s);
    qenc_trans_t t;
    t.valid   = 1'b0;
    t.illegal = 1'b0;
    t.dir     = QENC_DIR_CCW;
    case ({prev, s})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
        t.valid = 1'b1;
        t.dir   = QENC_DIR_CW;
      end
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
        t.valid = 1'b1;
        t.dir   = QENC_DIR_CCW;
      end
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
        t.illegal = 1'b1;
      end
      default: begin
      end
    endcase
    return t;
  endfunction

endpackage

// File: rtl/qenc_channel.sv
// One quadrature decoder channel.
// Ports:
//   clk, rst           system clock, async active-high reset
//   phase_a, phase_b   pre-synchronised encoder phases
//   mode               resolution select (x1/x2/x4, 11 behaves as x4)
//   clear              synchronous clear of position and error count
//   pos                signed position counter
//   err_cnt            saturating illegal-transition counter
//   step               one-cycle pulse per counted step
//   dir                direction of the last counted step (1 = CW)
// Macro QENC_SATURATE_EN: when defined the position saturates at the signed
// limits instead of wrapping.
module qenc_channel
  import qenc_pkg::*;
#(
  parameter int p_CNT_WIDTH = 8,
  parameter int p_ERR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   phase_a,
  input  logic                   phase_b,
  input  logic [1:0]             mode,
  input  logic                   clear,
  output logic [p_CNT_WIDTH-1:0] pos,
  output logic [p_ERR_WIDTH-1:0] err_cnt,
  output logic                   step,
  output logic                   dir
);

  localparam logic [p_CNT_WIDTH-1:0] POS_ONE = {{(p_CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef QENC_SATURATE_EN
  localparam logic [p_CNT_WIDTH-1:0] POS_MAX = {1'b0, {(p_CNT_WIDTH-1){1'b1}}};
  localparam logic [p_CNT_WIDTH-1:0] POS_MIN = {1'b1, {(p_CNT_WIDTH-1){1'b0}}};
`endif
  localparam logic [p_ERR_WIDTH-1:0] ERR_MAX = '1;

  logic [1:0]             cur;
  logic [1:0]             prev;
  logic                   primed;
  qenc_trans_t            trans;
  logic                   qualified;
  logic [p_CNT_WIDTH-1:0] pos_next;

  assign cur = {phase_a, phase_b};

  // Classify the transition and decide whether the current resolution
  // turns it into a counted step.
  always_comb begin
    trans     = qenc_decode(prev, cur);
    qualified = 1'b0;
    case (mode)
      QENC_MODE_X1: qualified = trans.valid && (cur == 2'b00);
      QENC_MODE_X2: qualified = trans.valid && (prev[1] != cur[1]);
      default:      qualified = trans.valid;
    endcase
  end

  // Candidate position after a counted step.
  always_comb begin
    pos_next = (trans.dir == QENC_DIR_CW) ? pos + POS_ONE : pos - POS_ONE;
`ifdef QENC_SATURATE_EN
    if ((trans.dir == QENC_DIR_CW) && (pos == POS_MAX)) begin
      pos_next = pos;
    end else if ((trans.dir == QENC_DIR_CCW) && (pos == POS_MIN)) begin
      pos_next = pos;
    end
`endif
  end

  // The first edge after reset only loads prev, so a non-00 resting state
  // is not mistaken for movement. Clear wins over any event but prev keeps
  // tracking the inputs so the next step is decoded correctly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 2'b00;
      primed  <= 1'b0;
      pos     <= '0;
      err_cnt <= '0;
      step    <= 1'b0;
      dir     <= 1'b0;
    end else begin
      prev   <= cur;
      primed <= 1'b1;
      step   <= 1'b0;
      if (clear) begin
        pos     <= '0;
        err_cnt <= '0;
      end else if (primed) begin
        if (trans.illegal) begin
          if (err_cnt != ERR_MAX) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end else if (qualified) begin
          pos  <= pos_next;
          dir  <= trans.dir;
          step <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quad_encoder_counter.sv
// Multi-channel quadrature decoder: p_CHANNELS independent qenc_channel
// instances with their outputs packed, channel 0 in the LSBs.
// Ports:
//   CLK, RST     system clock, async active-high reset
//   i_phase_a/b  per-channel phases, already synchronised to CLK
//   i_mode       00 x1, 01 x2, 10/11 x4
//   i_clear      per-channel synchronous clear
//   o_pos        packed signed positions (p_CNT_WIDTH each)
//   o_err_cnt    packed illegal-transition counts (p_ERR_WIDTH each)
//   o_step       per-channel one-cycle step pulse
//   o_dir        per-channel last step direction, 1 = CW
// Macro QENC_SATURATE_EN: position counters saturate instead of wrapping.
module quad_encoder_counter
  import qenc_pkg::*;
#(
  parameter int p_CHANNELS  = 2,
  parameter int p_CNT_WIDTH = 8,
  parameter int p_ERR_WIDTH = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [p_CHANNELS-1:0]             i_phase_a,
  input  logic [p_CHANNELS-1:0]             i_phase_b,
  input  logic [1:0]                        i_mode,
  input  logic [p_CHANNELS-1:0]             i_clear,
  output logic [p_CHANNELS*p_CNT_WIDTH-1:0] o_pos,
  output logic [p_CHANNELS*p_ERR_WIDTH-1:0] o_err_cnt,
  output logic [p_CHANNELS-1:0]             o_step,
  output logic [p_CHANNELS-1:0]             o_dir
);

  for (genvar k = 0; k < p_CHANNELS; k++) begin : g_chan
    qenc_channel #(
      .p_CNT_WIDTH(p_CNT_WIDTH),
      .p_ERR_WIDTH(p_ERR_WIDTH)
    ) u_chan (
      .clk     (CLK),
      .rst     (RST),
      .phase_a (i_phase_a[k]),
      .phase_b (i_phase_b[k]),
      .mode    (i_mode),
      .clear   (i_clear[k]),
      .pos     (o_pos[k*p_CNT_WIDTH +: p_CNT_WIDTH]),
      .err_cnt (o_err_cnt[k*p_ERR_WIDTH +: p_ERR_WIDTH]),
      .step    (o_step[k]),
      .dir     (o_dir[k])
    );
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Self-checking bench for quad_encoder_counter (2 channels, W=8, W_ERR=4).
// A behavioural model computes the expected outputs for every clock edge,
// pushes them onto a scoreboard queue, and each test pops and compares
// after the edge. Honours QENC_SATURATE_EN for the overflow expectation.
module tb_quad_encoder_counter;

  localparam int CH = 2;
  localparam int W  = 8;
  localparam int EW = 4;
  localparam int OBS_W = CH*W + CH*EW + 2*CH;

  typedef logic [OBS_W-1:0] obs_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [CH-1:0]     phase_a = '0;
  logic [CH-1:0]     phase_b = '0;
  logic [1:0]        mode = 2'b10;
  logic [CH-1:0]     clear = '0;
  logic [CH*W-1:0]   o_pos;
  logic [CH*EW-1:0]  o_err_cnt;
  logic [CH-1:0]     o_step;
  logic [CH-1:0]     o_dir;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [1:0] m_prev   [CH];
  logic       m_primed [CH];
  int         m_pos    [CH];
  int         m_err    [CH];
  logic       m_step   [CH];
  logic       m_dir    [CH];

  always #5 CLK = ~CLK;

  quad_encoder_counter #(
    .p_CHANNELS (CH),
    .p_CNT_WIDTH(W),
    .p_ERR_WIDTH(EW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .i_phase_a (phase_a),
    .i_phase_b (phase_b),
    .i_mode    (mode),
    .i_clear   (clear),
    .o_pos     (o_pos),
    .o_err_cnt (o_err_cnt),
    .o_step    (o_step),
    .o_dir     (o_dir)
  );

  // Position of a state along the CW cycle 00,01,11,10.
  function automatic int gray_idx(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_prev[k] = 2'b00; m_primed[k] = 1'b0; m_pos[k] = 0;
      m_err[k] = 0; m_step[k] = 1'b0; m_dir[k] = 1'b0;
    end
  endtask

  function automatic obs_t pack_expected();
    obs_t e;
    logic [W-1:0]  p;
    logic [EW-1:0] ec;
    e = '0;
    for (int k = 0; k < CH; k++) begin
      p  = W'(m_pos[k]);
      ec = EW'(m_err[k]);
      e[k]                          = m_dir[k];
      e[CH + k]                     = m_step[k];
      e[2*CH + k*EW +: EW]          = ec;
      e[2*CH + CH*EW + k*W +: W]    = p;
    end
    return e;
  endfunction

  task automatic set_ch(input int k, input logic [1:0] s);
    phase_a[k] = s[1];
    phase_b[k] = s[0];
  endtask

  // Advance the model for the coming edge, queue its prediction, clock once.
  task automatic apply_stimulus();
    logic [1:0] s;
    int         d;
    bit         counts;
    int         lim;
    lim = 1 << (W-1);
    for (int k = 0; k < CH; k++) begin
      s = {phase_a[k], phase_b[k]};
      m_step[k] = 1'b0;
      if (clear[k]) begin
        m_pos[k] = 0;
        m_err[k] = 0;
      end else if (m_primed[k]) begin
        d = (gray_idx(s) - gray_idx(m_prev[k]) + 4) % 4;
        if (d == 2) begin
          if (m_err[k] < (1 << EW) - 1) m_err[k]++;
        end else if (d != 0) begin
          if (mode == 2'b00)      counts = (s == 2'b00);
          else if (mode == 2'b01) counts = (s[1] != m_prev[k][1]);
          else                    counts = 1'b1;
          if (counts) begin
            m_step[k] = 1'b1;
            m_dir[k]  = (d == 1);
            m_pos[k]  = m_pos[k] + ((d == 1) ? 1 : -1);
`ifdef QENC_SATURATE_EN
            if (m_pos[k] > lim - 1) m_pos[k] = lim - 1;
            if (m_pos[k] < -lim)    m_pos[k] = -lim;
`else
            if (m_pos[k] > lim - 1) m_pos[k] -= 2*lim;
            if (m_pos[k] < -lim)    m_pos[k] += 2*lim;
`endif
          end
        end
      end
      m_primed[k] = 1'b1;
      m_prev[k]   = s;
    end
    exp_q.push_back(pack_expected());
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [CH-1:0] a, input logic [CH-1:0] b);
    phase_a = a; phase_b = b; clear = '0;
    RST = 1'b1;
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    do_reset(2'b11, 2'b11);
    mode = 2'b10;
    n_cmp++;
    if ({o_pos, o_err_cnt, o_step, o_dir} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_hold: got %h expected 0", {o_pos, o_err_cnt, o_step, o_dir});
    end
    repeat (5) begin
      apply_stimulus();
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_pos, o_err_cnt, o_step, o_dir} !== e) begin
        n_err++;
        $display("[TB] FAIL reset_sb: got %h expected %h", {o_pos, o_err_cnt, o_step, o_dir}, e);
      end
    end
    n_cmp++;
    if ({o_pos, o_err_cnt, o_step} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_prime: got pos %h err %h step %b, expected all 0", o_pos, o_err_cnt, o_step);
    end
  endtask

  task automatic test_x4();
    obs_t       e;
    int         steps;
    logic [1:0] cw  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] ccw [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    do_reset(2'b00, 2'b00);
    mode = 2'b10;
    apply_stimulus();
    void'(exp_q.pop_front());
    for (int dirn = 0; dirn < 2; dirn++) begin
      steps = 0;
      for (int i = 0; i < 4; i++) begin
        set_ch(0, (dirn == 0) ? cw[i] : ccw[i]);
        repeat (3) begin
          apply_stimulus();
          e = exp_q.pop_front();
          steps += int'(o_step[0]);
          n_cmp++;
          if ({o_pos, o_err_cnt, o_step, o_dir} !== e) begin
            n_err++;
            $display("[TB] FAIL x4_sb: got %h expected %h", {o_pos, o_err_cnt, o_step, o_dir}, e);
          end
        end
      end
      n_cmp++;
      if (steps != 4 || o_pos[W-1:0] !== ((dirn == 0) ? 8'd4 : 8'd0) || o_dir[0] !== (dirn == 0)) begin
        n_err++;
        $display("[TB] FAIL x4_cycle%0d: got steps %0d pos %0d dir %b, expected steps 4 pos %0d dir %0d",
                 dirn, steps, o_pos[W-1:0], o_dir[0], (dirn == 0) ? 4 : 0, (dirn == 0));
      end
    end
  endtask

  task automatic test_x1_x2();
    obs_t       e;
    logic [1:0] cw [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(2'b00, 2'b00);
    mode = 2'b00;
    apply_stimulus();
    void'(exp_q.pop_front());
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        set_ch(0, cw[i]);
        repeat (2) begin
          apply_stimulus();
          e = exp_q.pop_front();
          n_cmp++;
          if ({o_pos, o_err_cnt, o_step, o_dir} !== e) begin
            n_err++;
            $display("[TB] FAIL x1x2_sb: got %h expected %h", {o_pos, o_err_cnt, o_step, o_dir}, e);
          end
        end
      end
      n_cmp++;
      if (o_pos[W-1:0] !== ((pass == 0) ? 8'd1 : 8'd2)) begin
        n_err++;
        $display("[TB] FAIL %s_cycle: got pos %0d expected %0d",
                 (pass == 0) ? "x1" : "x2", o_pos[W-1:0], pass + 1);
      end
      if (pass == 0) begin
        clear = 2'b01;
        apply_stimulus();
        e = exp_q.pop_front();
        clear = 2'b00;
        mode  = 2'b01;
        n_cmp++;
        if ({o_pos, o_err_cnt, o_step, o_dir} !== e) begin
          n_err++;
          $display("[TB] FAIL x1x2_clear: got %h expected %h", {o_pos, o_err_cnt, o_step, o_dir}, e);
        end
      end
    end
  endtask

  task automatic test_illegal();
    obs_t e;
    do_reset(2'b00, 2'b00);
    mode = 2'b10;
    apply_stimulus();
    void'(exp_q.pop_front());
    for (int j = 0; j < 20; j++) begin
      set_ch(1, (j % 2 == 0) ? 2'b11 : 2'b00);
      repeat (2) begin
        apply_stimulus();
        e = exp_q.pop_front();
        n_cmp++;
        if ({o_pos, o_err_cnt, o_step, o_dir} !== e) begin
          n_err++;
          $display("[TB] FAIL illegal_sb: got %h expected %h", {o_pos, o_err_cnt, o_step, o_dir}, e);
        end
      end
      if (j == 0) begin
        n_cmp++;
        if (o_err_cnt[2*EW-1:EW] !== 4'd1 || o_pos[2*W-1:W] !== 8'd0 || o_step[1] !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL illegal_first: got err %0d pos %0d step %b, expected err 1 pos 0 step 0",
                   o_err_cnt[2*EW-1:EW], o_pos[2*W-1:W], o_step[1]);
        end
      end
    end
    n_cmp++;
    if (o_err_cnt[2*EW-1:EW] !== 4'd15 || o_err_cnt[EW-1:0] !== 4'd0) begin
      n_err++;
      $display("[TB] FAIL illegal_sat: got err1 %0d err0 %0d, expected 15 and 0",
               o_err_cnt[2*EW-1:EW], o_err_cnt[EW-1:0]);
    end
  endtask

  task automatic test_overflow();
    obs_t       e;
    logic [W-1:0] want;
    logic [1:0] cw [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    do_reset(2'b00, 2'b00);
    mode = 2'b11;
    apply_stimulus();
    void'(exp_q.pop_front());
    for (int i = 0; i < 128; i++) begin
      set_ch(0, cw[i % 4]);
      apply_stimulus();
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_pos, o_err_cnt, o_step, o_dir} !== e) begin
        n_err++;
        $display("[TB] FAIL ovf_sb: got %h expected %h", {o_pos, o_err_cnt, o_step, o_dir}, e);
      end
      if (i == 126) begin
        n_cmp++;
        if (o_pos[W-1:0] !== 8'h7F) begin
          n_err++;
          $display("[TB] FAIL ovf_preload: got pos %h expected 7f", o_pos[W-1:0]);
        end
      end
    end
`ifdef QENC_SATURATE_EN
    want = 8'h7F;
`else
    want = 8'h80;
`endif
    n_cmp++;
    if (o_pos[W-1:0] !== want || o_step[0] !== 1'b1 || o_dir[0] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL ovf_edge: got pos %h step %b dir %b, expected pos %h step 1 dir 1",
               o_pos[W-1:0], o_step[0], o_dir[0], want);
    end
  endtask

  task automatic test_clear_collision();
    obs_t e;
    do_reset(2'b00, 2'b00);
    mode = 2'b10;
    apply_stimulus();
    void'(exp_q.pop_front());
    set_ch(0, 2'b01); apply_stimulus(); void'(exp_q.pop_front());
    set_ch(0, 2'b11); apply_stimulus(); void'(exp_q.pop_front());
    set_ch(0, 2'b10);
    set_ch(1, 2'b01);
    clear = 2'b01;
    apply_stimulus();
    e = exp_q.pop_front();
    clear = 2'b00;
    n_cmp++;
    if ({o_pos, o_err_cnt, o_step, o_dir} !== e) begin
      n_err++;
      $display("[TB] FAIL clear_sb: got %h expected %h", {o_pos, o_err_cnt, o_step, o_dir}, e);
    end
    n_cmp++;
    if (o_pos[W-1:0] !== 8'd0 || o_step !== 2'b10 || o_pos[2*W-1:W] !== 8'd1) begin
      n_err++;
      $display("[TB] FAIL clear_collide: got pos0 %0d pos1 %0d step %b, expected 0 1 10",
               o_pos[W-1:0], o_pos[2*W-1:W], o_step);
    end
    set_ch(0, 2'b00);
    apply_stimulus();
    e = exp_q.pop_front();
    n_cmp++;
    if ({o_pos, o_err_cnt, o_step, o_dir} !== e || o_pos[W-1:0] !== 8'd1) begin
      n_err++;
      $display("[TB] FAIL clear_track: got %h expected %h (pos0 1)", {o_pos, o_err_cnt, o_step, o_dir}, e);
    end
  endtask

  task automatic test_reset_midrun();
    obs_t e;
    // Channel state is non-zero here after the previous test.
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    n_cmp++;
    if ({o_pos, o_err_cnt, o_step, o_dir} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_async: got %h expected 0", {o_pos, o_err_cnt, o_step, o_dir});
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    set_ch(0, 2'b11);
    set_ch(1, 2'b10);
    repeat (2) begin
      apply_stimulus();
      e = exp_q.pop_front();
      n_cmp++;
      if ({o_pos, o_err_cnt, o_step, o_dir} !== e) begin
        n_err++;
        $display("[TB] FAIL reset_reprime: got %h expected %h", {o_pos, o_err_cnt, o_step, o_dir}, e);
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_x4();
    test_x1_x2();
    test_illegal();
    test_overflow();
    test_clear_collision();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
